// File: rtl/gdp_host_pkg.sv
// Shared types and defaults for the GDP initiator (gdp_host).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gdp_host_pkg;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_TIMEOUT        = 64;
    localparam int DEF_RESTART_CYCLES = 2;

    // Host sequencing states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        WAIT   = 3'd2,
        CLEAN  = 3'd3,
        RESULT = 3'd4
    } state_t;

    // Bits needed to hold 0..max_count; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/gdp_host_wdog.sv
// Clearable saturating cycle counter with terminal-count flag.
// Latency: tc_o is registered state; clear/enable act on the next edge.
// Backpressure: none; the counter simply holds at MAX_COUNT.
module gdp_host_wdog
    import gdp_host_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 63
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned   CW     = cnt_width(MAX_COUNT);
    localparam logic [CW-1:0] TC_VAL = CW'(MAX_COUNT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear has priority; counting stops at the terminal value so it never wraps
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != TC_VAL)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/gdp_host.sv
// Initiator for the count-ones GDP: operand in, start/done/restart handshake, {operand,count} out.
// Latency: op accept -> gdp_start 1 cycle; gdp_done -> res_valid RESTART_CYCLES+1 cycles.
// Backpressure: op_ready only in IDLE; result held until res_ready. Optional GDP_HOST_CHECK_EN adds res_mismatch.
module gdp_host
    import gdp_host_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT        = DEF_TIMEOUT,
    parameter int RESTART_CYCLES = DEF_RESTART_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_data,
    output logic [WIDTH-1:0] gdp_n_in,
    output logic             gdp_start,
    output logic             gdp_restart,
    input  logic [WIDTH-1:0] gdp_run_sum,
    input  logic             gdp_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_n,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_err,
    output logic             busy
`ifdef GDP_HOST_CHECK_EN
    ,
    output logic             res_mismatch
`endif
);

    state_t           state_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] sum_q;
    logic             err_q;
    logic             start_q;
    logic             restart_q;
    logic             res_valid_q;
    logic             op_ready_q;
    logic             busy_q;

    logic             wait_tc;
    logic             clean_tc;

    // Timer is held at zero through IDLE so it reads 0 during START and
    // counts from there; the abort fires TIMEOUT cycles after gdp_start.
    gdp_host_wdog #(
        .MAX_COUNT (TIMEOUT - 1)
    ) u_wait_wdog (
        .clock (clock),
        .reset (reset),
        .clr_i (state_q == IDLE),
        .en_i  ((state_q == START) || (state_q == WAIT)),
        .tc_o  (wait_tc)
    );

    // Same counter type measures how long restart has been held in CLEAN
    gdp_host_wdog #(
        .MAX_COUNT (RESTART_CYCLES - 1)
    ) u_clean_wdog (
        .clock (clock),
        .reset (reset),
        .clr_i (state_q != CLEAN),
        .en_i  (state_q == CLEAN),
        .tc_o  (clean_tc)
    );

`ifdef GDP_HOST_CHECK_EN
    logic [WIDTH-1:0] ones_cnt;
    logic             mismatch_q;

    // Independent population count of the latched operand for the capture cross-check
    always_comb begin
        ones_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_cnt = ones_cnt + WIDTH'(n_q[i]);
        end
    end
`endif

    // Sequencer: every handshake output is a register updated with the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            sum_q       <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            restart_q   <= 1'b0;
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GDP_HOST_CHECK_EN
            mismatch_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    op_ready_q <= 1'b1;
                    if (op_valid && op_ready_q) begin
                        n_q        <= op_data;
                        op_ready_q <= 1'b0;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done seen on the timeout cycle still counts as a normal finish
                    if (gdp_done) begin
                        sum_q     <= gdp_run_sum;
                        err_q     <= 1'b0;
                        restart_q <= 1'b1;
                        state_q   <= CLEAN;
`ifdef GDP_HOST_CHECK_EN
                        mismatch_q <= (ones_cnt != gdp_run_sum);
`endif
                    end else if (wait_tc) begin
                        sum_q     <= '0;
                        err_q     <= 1'b1;
                        restart_q <= 1'b1;
                        state_q   <= CLEAN;
`ifdef GDP_HOST_CHECK_EN
                        mismatch_q <= 1'b0;
`endif
                    end
                end
                CLEAN: begin
                    if (clean_tc) begin
                        restart_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
`ifdef GDP_HOST_CHECK_EN
                        mismatch_q  <= 1'b0;
`endif
                    end
                end
                default: begin
                    start_q     <= 1'b0;
                    restart_q   <= 1'b0;
                    res_valid_q <= 1'b0;
                    op_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Operand register feeds the GDP directly, so n_in is stable START..CLEAN
    assign gdp_n_in    = n_q;
    assign gdp_start   = start_q;
    assign gdp_restart = restart_q;
    assign op_ready    = op_ready_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_n       = n_q;
    assign res_sum     = sum_q;
    assign res_err     = err_q;
`ifdef GDP_HOST_CHECK_EN
    assign res_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_gdp_host.sv
// Self-checking bench for gdp_host with a behavioural GDP and a cycle-level expectation model.
// Latency: n/a.
// Backpressure: exercises res_ready held low and async reset mid-transaction.
module tb_gdp_host;

    localparam int W   = 8;
    localparam int TO  = 64;
    localparam int RC  = 2;

    logic         clock;
    logic         reset;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_data;
    logic [W-1:0] gdp_n_in;
    logic         gdp_start;
    logic         gdp_restart;
    logic [W-1:0] gdp_run_sum;
    logic         gdp_done;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_n;
    logic [W-1:0] res_sum;
    logic         res_err;
    logic         busy;
`ifdef GDP_HOST_CHECK_EN
    logic         res_mismatch;
`endif

    gdp_host #(.WIDTH(W), .TIMEOUT(TO), .RESTART_CYCLES(RC)) dut (
        .clock       (clock),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_data     (op_data),
        .gdp_n_in    (gdp_n_in),
        .gdp_start   (gdp_start),
        .gdp_restart (gdp_restart),
        .gdp_run_sum (gdp_run_sum),
        .gdp_done    (gdp_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_n       (res_n),
        .res_sum     (res_sum),
        .res_err     (res_err),
        .busy        (busy)
`ifdef GDP_HOST_CHECK_EN
        ,
        .res_mismatch(res_mismatch)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // GDP behaviour configuration, set by the stimulus before each operand
    logic [W-1:0] cfg_sum   = '0;
    bit           cfg_hang  = 0;
    int           cfg_delay = 10;
    bit           stale     = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural GDP: done (with run_sum) cfg_delay cycles after start, cleared by restart
    initial begin : gdp_model
        int cnt;
        bit pend;
        cnt = 0;
        pend = 0;
        gdp_done = 1'b0;
        gdp_run_sum = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                gdp_done = 1'b0;
                gdp_run_sum = '0;
                pend = 0;
            end else if (gdp_restart) begin
                gdp_done = 1'b0;
                gdp_run_sum = '0;
                pend = 0;
            end else if (gdp_start) begin
                gdp_done = 1'b0;
                pend = !cfg_hang;
                cnt = cfg_delay;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    gdp_done = 1'b1;
                    gdp_run_sum = cfg_sum;
                    pend = 0;
                end
            end
            if (stale) begin
                gdp_done = 1'b1;
                gdp_run_sum = 8'h55;
            end
        end
    end

    // Expectation model: derives every output from transaction timing rules
    bit           m_busy = 0;
    bit           m_after = 0;
    bit           m_done_seen = 0;
    int           m_s = 0;
    int           m_rs = 0;
    logic [W-1:0] m_n = '0;
    logic [W-1:0] m_sum = '0;
    bit           m_err = 0;
    bit           m_mm = 0;

    always @(negedge clock) begin
        if (reset) begin
            m_busy = 0;
            m_after = 0;
        end else if (m_busy) begin
            if (gdp_done && (cyc > m_s) && (cyc < m_rs) && !m_done_seen) begin
                m_done_seen = 1;
                m_rs = cyc + 1;
            end
            chk("start", gdp_start, (cyc == m_s));
            chk("restart", gdp_restart, (cyc >= m_rs) && (cyc < m_rs + RC));
            chk("res_valid", res_valid, (cyc >= m_rs + RC));
            chk("op_ready_busy", op_ready, 0);
            chk("busy_hi", busy, 1);
            chk("n_in", gdp_n_in, m_n);
            if (cyc >= m_rs + RC) begin
                chk("res_n", res_n, m_n);
                chk("res_sum", res_sum, m_sum);
                chk("res_err", res_err, m_err);
`ifdef GDP_HOST_CHECK_EN
                chk("res_mismatch", res_mismatch, m_mm);
`endif
                if (res_ready) begin
                    m_busy = 0;
                    m_after = 1;
                end
            end
        end else begin
            chk("idle_start", gdp_start, 0);
            chk("idle_restart", gdp_restart, 0);
            chk("idle_res_valid", res_valid, 0);
            chk("busy_lo", busy, 0);
            if (m_after) chk("op_ready_after", op_ready, 1);
            m_after = 0;
            if (op_valid && op_ready) begin
                m_busy = 1;
                m_s = cyc + 1;
                m_rs = m_s + TO;
                m_done_seen = 0;
                m_n = op_data;
                m_sum = cfg_hang ? '0 : cfg_sum;
                m_err = cfg_hang;
                m_mm = !cfg_hang && ($countones(op_data) != cfg_sum);
            end
        end
    end

    // sel: 0 gdp_start, 1 gdp_restart, 2 res_valid, 3 op_ready; returns the cycle seen
    task automatic wait_for(input int sel, input string name, output int at);
        bit found;
        found = 0;
        at = -1;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clock);
            if ((sel == 0 && gdp_start) || (sel == 1 && gdp_restart) ||
                (sel == 2 && res_valid) || (sel == 3 && op_ready)) begin
                found = 1;
                at = cyc;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_%s: got no event expected one within 400 cycles", name);
        end
    endtask

    task automatic send(input logic [W-1:0] op, input logic [W-1:0] sum, input bit hang,
                        input int dly, output int hs);
        @(posedge clock);
        #1;
        cfg_sum = sum;
        cfg_hang = hang;
        cfg_delay = dly;
        op_data = op;
        op_valid = 1'b1;
        wait_for(3, "op_ready", hs);
        @(posedge clock);
        #1;
        op_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stim
        int hs, t0, t1, rv;
        logic [W-1:0] ops  [3];
        logic [W-1:0] sums [3];
        ops  = '{8'h00, 8'hFF, 8'h01};
        sums = '{8'h00, 8'h08, 8'h01};
        reset = 1'b1;
        op_valid = 1'b0;
        op_data = '0;
        res_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_op_ready", op_ready, 0);
        chk("rst_start", gdp_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_n_in", gdp_n_in, 0);
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b0;

        // Normal: B5 -> 5 after 10 cycles
        send(8'hB5, 8'd5, 0, 10, hs);
        wait_for(0, "start", t0);
        chk("lat_start", t0 - hs, 1);
        wait_for(1, "restart", t1);
        chk("done_to_restart", t1 - t0, 11);
        wait_for(2, "res_valid", rv);
        chk("restart_len", rv - t1, RC);
        chk("start_to_res", rv - t0, 13);
        chk("b5_n", res_n, 8'hB5);
        chk("b5_sum", res_sum, 8'd5);
        chk("b5_err", res_err, 0);

        // Back-to-back with res_ready held high
        for (int i = 0; i < 3; i++) begin
            send(ops[i], sums[i], 0, 3 + i, hs);
            wait_for(2, "res_valid_b2b", rv);
            chk("b2b_n", res_n, ops[i]);
            chk("b2b_sum", res_sum, sums[i]);
        end

        // Timeout: GDP never answers
        send(8'hA5, 8'd4, 1, 10, hs);
        wait_for(0, "start_to", t0);
        wait_for(1, "restart_to", t1);
        chk("timeout_gap", t1 - t0, TO);
        wait_for(2, "res_valid_to", rv);
        chk("to_err", res_err, 1);
        chk("to_sum", res_sum, 0);
        chk("to_n", res_n, 8'hA5);
        send(8'h3C, 8'd4, 0, 5, hs);
        wait_for(2, "res_valid_after_to", rv);
        chk("after_to_sum", res_sum, 8'd4);
        chk("after_to_err", res_err, 0);

        // Backpressure: result must hold for 20 cycles
        @(posedge clock);
        #1 res_ready = 1'b0;
        send(8'h81, 8'd2, 0, 4, hs);
        wait_for(2, "res_valid_bp", rv);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clock);
            chk("bp_valid", res_valid, 1);
            chk("bp_n", res_n, 8'h81);
            chk("bp_sum", res_sum, 8'd2);
            chk("bp_op_ready", op_ready, 0);
        end
        @(posedge clock);
        #1 res_ready = 1'b1;
        @(negedge clock);
        chk("bp_hs_valid", res_valid, 1);
        @(negedge clock);
        chk("bp_released", res_valid, 0);
        chk("bp_op_ready_back", op_ready, 1);

        // Async reset between edges during WAIT, then stale done while idle
        send(8'h77, 8'd6, 0, 30, hs);
        wait_for(0, "start_rst", t0);
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_start", gdp_start, 0);
        chk("arst_restart", gdp_restart, 0);
        chk("arst_busy", busy, 0);
        chk("arst_op_ready", op_ready, 0);
        chk("arst_n_in", gdp_n_in, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_res_sum", res_sum, 0);
        chk("arst_res_err", res_err, 0);
        stale = 1;
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            chk("stale_busy", busy, 0);
            chk("stale_start", gdp_start, 0);
        end
        stale = 0;
        send(8'h33, 8'd4, 0, 6, hs);
        wait_for(2, "res_valid_post_rst", rv);
        chk("post_rst_sum", res_sum, 8'd4);
        chk("post_rst_n", res_n, 8'h33);

`ifdef GDP_HOST_CHECK_EN
        send(8'h0F, 8'd3, 0, 5, hs);
        wait_for(2, "res_valid_mm", rv);
        chk("mm_bad", res_mismatch, 1);
        send(8'h0F, 8'd4, 0, 5, hs);
        wait_for(2, "res_valid_mm2", rv);
        chk("mm_good", res_mismatch, 0);
`endif

        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
